// File: rtl/generic_fir_if.sv
// Sample/tap/result bundle between generic_fir and its source and sink.
// The filter sits on the slave side; the driving environment uses master.
interface generic_fir_if #(
   parameter int NTAPS = 8,
   parameter int IW    = 12,
   parameter int TW    = IW,
   parameter int OW    = 2*IW+7
);
   logic                 i_ce;
   logic signed [IW-1:0] i_sample;
   logic                 i_tap_wr;
   logic signed [TW-1:0] i_new_tap [NTAPS:0];
   logic [15:0]          i_output_lenght;
   logic signed [OW-1:0] o_result;
   logic                 o_valid_first;
   logic                 o_valid_result;
   logic                 o_clean_pip;

   modport slave (
      input  i_ce, i_sample, i_tap_wr, i_new_tap, i_output_lenght,
      output o_result, o_valid_first, o_valid_result, o_clean_pip
   );

   modport master (
      output i_ce, i_sample, i_tap_wr, i_new_tap, i_output_lenght,
      input  o_result, o_valid_first, o_valid_result, o_clean_pip
   );
endinterface

// File: rtl/generic_fir.sv
// Frame-based, fully parallel FIR producing the full-length convolution of one frame.
// After the frame it drains NTAPS zero-fed results, then idles in DONE until reset (NTAPS >= 1).
module generic_fir #(
   parameter int NTAPS = 8,
   parameter int IW    = 12,
   parameter int TW    = IW,
   parameter int OW    = 2*IW+7
) (
   input logic          i_clk,
   input logic          i_reset,
   generic_fir_if.slave bus
);
   localparam int PW = IW + TW;

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

   state_t               state_q, state_d;
   logic signed [TW-1:0] tap_q  [NTAPS:0];
   logic signed [IW-1:0] hist_q [NTAPS:1];
   logic signed [IW-1:0] hist_d [NTAPS:1];
   logic signed [IW-1:0] win    [NTAPS:0];
   logic signed [PW-1:0] prod;
   logic signed [OW-1:0] acc;
   logic signed [OW-1:0] result_q, result_d;
   logic                 valid_first_q, valid_first_d;
   logic                 valid_q, valid_d;
   logic                 clean_q, clean_d;
   logic [15:0]          in_cnt_q, in_cnt_d;
   logic [15:0]          len_q, len_d;
   logic [15:0]          flush_cnt_q, flush_cnt_d;
   logic [15:0]          len_eff;
   logic                 step;

   // Taps load on any edge with i_tap_wr, regardless of state or clock enable.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int k = 0; k <= NTAPS; k++) tap_q[k] <= '0;
      end else if (bus.i_tap_wr) begin
         for (int k = 0; k <= NTAPS; k++) tap_q[k] <= bus.i_new_tap[k];
      end
   end

   // hist_q[k] holds the sample that becomes x[n-k] on the next accepted step.
   always_comb begin
      step   = bus.i_ce && (state_q != DONE);
      win[0] = (state_q == RUN) ? bus.i_sample : '0;
      for (int k = 1; k <= NTAPS; k++) win[k] = hist_q[k];
      acc  = '0;
      prod = '0;
      for (int k = 0; k <= NTAPS; k++) begin
         prod = PW'(tap_q[k]) * PW'(win[k]);
         acc  = acc + OW'(prod);
      end
   end

   // Frame length is latched on the first accepted sample; zero is treated as one.
   always_comb begin
      state_d       = state_q;
      result_d      = result_q;
      valid_first_d = 1'b0;
      valid_d       = 1'b0;
      clean_d       = clean_q;
      in_cnt_d      = in_cnt_q;
      len_d         = len_q;
      flush_cnt_d   = flush_cnt_q;
      for (int k = 1; k <= NTAPS; k++) hist_d[k] = hist_q[k];

      if (in_cnt_q == 16'd0) begin
         len_eff = (bus.i_output_lenght == 16'd0) ? 16'd1 : bus.i_output_lenght;
      end else begin
         len_eff = len_q;
      end

      if (step) begin
         result_d  = acc;
         valid_d   = 1'b1;
         hist_d[1] = win[0];
         for (int k = 2; k <= NTAPS; k++) hist_d[k] = hist_q[k-1];

         unique case (state_q)
            RUN: begin
               valid_first_d = (in_cnt_q == 16'd0);
               len_d         = len_eff;
               in_cnt_d      = in_cnt_q + 16'd1;
               if (({1'b0, in_cnt_q} + 17'd1) == {1'b0, len_eff}) begin
                  state_d     = FLUSH;
                  flush_cnt_d = '0;
                  clean_d     = 1'b1;
               end
            end
            FLUSH: begin
               flush_cnt_d = flush_cnt_q + 16'd1;
               if ((flush_cnt_q + 16'd1) == 16'(NTAPS)) begin
                  state_d = DONE;
                  clean_d = 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= RUN;
         result_q      <= '0;
         valid_first_q <= 1'b0;
         valid_q       <= 1'b0;
         clean_q       <= 1'b0;
         in_cnt_q      <= '0;
         len_q         <= '0;
         flush_cnt_q   <= '0;
         for (int k = 1; k <= NTAPS; k++) hist_q[k] <= '0;
      end else begin
         state_q       <= state_d;
         result_q      <= result_d;
         valid_first_q <= valid_first_d;
         valid_q       <= valid_d;
         clean_q       <= clean_d;
         in_cnt_q      <= in_cnt_d;
         len_q         <= len_d;
         flush_cnt_q   <= flush_cnt_d;
         for (int k = 1; k <= NTAPS; k++) hist_q[k] <= hist_d[k];
      end
   end

   assign bus.o_result       = result_q;
   assign bus.o_valid_first  = valid_first_q;
   assign bus.o_valid_result = valid_q;
   assign bus.o_clean_pip    = clean_q;
endmodule

// File: tb/tb_generic_fir.sv
// Self-checking bench for generic_fir: directed and random frames compared
// against a plain full-convolution reference model.
module tb_generic_fir;
   localparam int NTAPS = 8;
   localparam int IW    = 12;
   localparam int TW    = 12;
   localparam int OW    = 31;

   logic i_clk = 1'b0;
   logic i_reset;

   always #5 i_clk = ~i_clk;

   generic_fir_if #(.NTAPS(NTAPS), .IW(IW), .TW(TW), .OW(OW)) bus ();

   generic_fir #(.NTAPS(NTAPS), .IW(IW), .TW(TW), .OW(OW)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .bus     (bus)
   );

   int     vectors     = 0;
   int     miscompares = 0;
   int     tapVals [NTAPS+1];
   int     frame [$];
   longint expY [$];

   // Every comparison funnels through here so the counters stay in one place.
   task automatic checkOutput(input string tag, input logic signed [63:0] observed,
                              input logic signed [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs and return 1 time unit after the rising edge.
   task automatic applyStimulus(input logic ce, input int sample);
      bus.i_ce     = ce;
      bus.i_sample = IW'(sample);
      @(posedge i_clk);
      #1;
   endtask

   task automatic doReset();
      i_reset     = 1'b1;
      bus.i_ce    = 1'b0;
      bus.i_tap_wr = 1'b0;
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = 0;
      #2;
      checkOutput("rstResult", bus.o_result, 0);
      checkOutput("rstValid", bus.o_valid_result, 0);
      checkOutput("rstFirst", bus.o_valid_first, 0);
      checkOutput("rstClean", bus.o_clean_pip, 0);
      #1;
      i_reset = 1'b0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic loadTaps();
      for (int k = 0; k <= NTAPS; k++) bus.i_new_tap[k] = TW'(tapVals[k]);
      bus.i_tap_wr = 1'b1;
      applyStimulus(1'b0, 0);
      bus.i_tap_wr = 1'b0;
   endtask

   function automatic int randSample();
      return int'($urandom_range(0, 4095)) - 2048;
   endfunction

   // Reference: full-length convolution of the frame with the current taps.
   function automatic void buildModel(input int effN);
      longint s;
      expY.delete();
      for (int n = 0; n < effN + NTAPS; n++) begin
         s = 0;
         for (int k = 0; k <= NTAPS; k++) begin
            if ((n - k) >= 0 && (n - k) < effN) s += longint'(tapVals[k]) * longint'(frame[n-k]);
         end
         expY.push_back(s);
      end
   endfunction

   task automatic checkResult(input int idx, input int effN);
      checkOutput($sformatf("result[%0d]", idx), bus.o_result, expY[idx]);
      checkOutput($sformatf("valid[%0d]", idx), bus.o_valid_result, 1);
      checkOutput($sformatf("first[%0d]", idx), bus.o_valid_first, (idx == 0) ? 1 : 0);
      checkOutput($sformatf("clean[%0d]", idx), bus.o_clean_pip,
                  (idx >= effN - 1 && idx < effN + NTAPS - 1) ? 1 : 0);
   endtask

   // Runs one frame right after reset; the flush is driven with i_ce = o_clean_pip.
   task automatic runFrame(input int nLen, input int gapAt, input int lenAfterFirst);
      int effN;
      effN = (nLen == 0) ? 1 : nLen;
      buildModel(effN);
      bus.i_output_lenght = 16'(nLen);
      for (int i = 0; i < effN; i++) begin
         if (i == gapAt) begin
            for (int g = 0; g < 3; g++) begin
               applyStimulus(1'b0, randSample());
               checkOutput("gapValid", bus.o_valid_result, 0);
               checkOutput("gapFirst", bus.o_valid_first, 0);
               checkOutput("gapHold", bus.o_result, expY[i-1]);
            end
         end
         applyStimulus(1'b1, frame[i]);
         if (i == 0) bus.i_output_lenght = 16'(lenAfterFirst);
         checkResult(i, effN);
      end
      for (int j = 0; j < NTAPS; j++) begin
         applyStimulus(bus.o_clean_pip, randSample());
         checkResult(effN + j, effN);
      end
      applyStimulus(1'b1, randSample());
      checkOutput("doneValid", bus.o_valid_result, 0);
      checkOutput("doneFirst", bus.o_valid_first, 0);
      checkOutput("doneClean", bus.o_clean_pip, 0);
      checkOutput("doneHold", bus.o_result, expY[effN+NTAPS-1]);
   endtask

   initial begin
      int n;
      i_reset             = 1'b1;
      bus.i_ce            = 1'b0;
      bus.i_sample        = '0;
      bus.i_tap_wr        = 1'b0;
      bus.i_output_lenght = 16'd1;
      for (int k = 0; k <= NTAPS; k++) bus.i_new_tap[k] = '0;

      $display("[TB] impulse, N=1");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = 8 + k;
      loadTaps();
      frame = '{1};
      runFrame(1, -1, 1);

      $display("[TB] impulse frame, N=8");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = 8 + k;
      loadTaps();
      frame = '{1, 0, 0, 0, 0, 0, 0, 0};
      runFrame(8, -1, 8);

      $display("[TB] step input with a 3-cycle enable gap, N=9");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = 8 + k;
      loadTaps();
      frame = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
      runFrame(9, 4, 9);

      $display("[TB] signed extremes, N=9");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = -2048;
      loadTaps();
      frame.delete();
      for (int i = 0; i < 9; i++) frame.push_back(-2048);
      runFrame(9, -1, 9);

      $display("[TB] zero length treated as one");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = randSample();
      loadTaps();
      frame = '{randSample()};
      runFrame(0, -1, 5);

      for (int r = 0; r < 4; r++) begin
         $display("[TB] random frame %0d", r);
         doReset();
         for (int k = 0; k <= NTAPS; k++) tapVals[k] = randSample();
         loadTaps();
         n = int'($urandom_range(3, 12));
         frame.delete();
         for (int i = 0; i < n; i++) frame.push_back(randSample());
         runFrame(n, int'($urandom_range(1, n - 1)), int'($urandom_range(1, 20)));
      end

      $display("[TB] reset during flush");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = randSample();
      loadTaps();
      bus.i_output_lenght = 16'd4;
      for (int i = 0; i < 4; i++) applyStimulus(1'b1, randSample());
      applyStimulus(1'b1, 0);
      applyStimulus(1'b1, 0);
      checkOutput("midFlushClean", bus.o_clean_pip, 1);
      doReset();
      frame = '{randSample(), randSample(), randSample()};
      runFrame(3, -1, 3);

      $display("[TB] fresh frame after reset with reloaded taps");
      doReset();
      for (int k = 0; k <= NTAPS; k++) tapVals[k] = randSample();
      loadTaps();
      frame = '{randSample(), randSample(), randSample(), randSample(), randSample()};
      runFrame(5, 2, 5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
